// File: rtl/hex_display_sweeper.sv
// Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS digits,
// capturing each decoded pattern into a per-digit output register.
module hex_display_sweeper #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [3:0]              dec_sw,
  input  logic [6:0]              dec_hex,
  output logic [7*NUM_DIGITS-1:0] hex_flat,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE  = CW'(1);
  localparam logic [IW+2:0] SEG_W    = (IW+3)'(7);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                    state_r, state_nxt;
  logic [IW-1:0]             idx_r, idx_nxt;
  logic [4*NUM_DIGITS-1:0]   shadow_r, shadow_nxt;
  logic [4*NUM_DIGITS-1:0]   pbuf_r, pbuf_nxt;
  logic                      pend_r, pend_nxt;
  logic [NUM_DIGITS-1:0]     mask_r, mask_nxt;
  logic [3:0]                dec_sw_r, dec_sw_nxt;
  logic [7*NUM_DIGITS-1:0]   hex_r, hex_nxt;
  logic                      busy_r, busy_nxt;
  logic                      done_r, done_nxt;
  logic [CW-1:0]             div_r;
  logic                      tick_s;
  logic [IW+2:0]             off_s;

  // Digit i>=1 is blanked when it and every more significant nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v,
                                                    input logic en);
    logic zeros;
    zeros   = 1'b1;
    lz_mask = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros      = zeros & (v[4*i +: 4] == 4'h0);
      lz_mask[i] = zeros & en;
    end
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [4*NUM_DIGITS-1:0] v,
                                            input logic [IW-1:0] k);
    nibble_sel = v[{k, 2'b00} +: 4];
  endfunction

  assign tick_s = (div_r == DIV_LAST);

  // Free-running refresh divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= {CW{1'b0}};
    end else if (tick_s) begin
      div_r <= {CW{1'b0}};
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Sweep sequencing: next state plus next value of every registered output.
  always_comb begin
    state_nxt  = state_r;
    idx_nxt    = idx_r;
    shadow_nxt = shadow_r;
    pbuf_nxt   = pbuf_r;
    pend_nxt   = pend_r;
    mask_nxt   = mask_r;
    dec_sw_nxt = dec_sw_r;
    hex_nxt    = hex_r;
    busy_nxt   = busy_r;
    done_nxt   = 1'b0;
    off_s      = {3'b000, idx_r} * SEG_W;

    case (state_r)
      IDLE: begin
        if (load || pend_r || tick_s) begin
          if (load) begin
            shadow_nxt = value;
          end else if (pend_r) begin
            shadow_nxt = pbuf_r;
          end else begin
            shadow_nxt = shadow_r;
          end
          pend_nxt   = 1'b0;
          idx_nxt    = {IW{1'b0}};
          busy_nxt   = 1'b1;
          mask_nxt   = lz_mask(shadow_nxt, blank_lz);
          dec_sw_nxt = shadow_nxt[3:0];
          state_nxt  = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRIVE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (mask_r[idx_r]) begin
          hex_nxt[off_s +: 7] = 7'h7F;
        end else begin
          hex_nxt[off_s +: 7] = dec_hex;
        end
        if (idx_r == IDX_LAST) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt    = idx_r + IDX_ONE;
          dec_sw_nxt = nibble_sel(shadow_r, idx_nxt);
          state_nxt  = DRIVE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // A load arriving mid-sweep is deferred; only the latest one is kept.
    if (load && (state_r != IDLE)) begin
      pend_nxt = 1'b1;
      pbuf_nxt = value;
    end else begin
      pbuf_nxt = pbuf_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      idx_r    <= {IW{1'b0}};
      shadow_r <= {(4*NUM_DIGITS){1'b0}};
      pbuf_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_r   <= 1'b0;
      mask_r   <= {NUM_DIGITS{1'b0}};
      dec_sw_r <= 4'h0;
      hex_r    <= {NUM_DIGITS{7'h7F}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      idx_r    <= idx_nxt;
      shadow_r <= shadow_nxt;
      pbuf_r   <= pbuf_nxt;
      pend_r   <= pend_nxt;
      mask_r   <= mask_nxt;
      dec_sw_r <= dec_sw_nxt;
      hex_r    <= hex_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
    end
  end

  assign dec_sw   = dec_sw_r;
  assign hex_flat = hex_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
